// File: rtl/coin_input_conditioner.sv
// Coin input front end: synchronises and debounces the insert button,
// captures the coin code and counts accepted coins.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic [1:0]       coins_raw,
  output logic             insert,
  output logic [1:0]       coins,
  output logic             coin_reject,
  output logic [CNT_W-1:0] accepted_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DEB_PRESS   = 3'd1,
    PRESSED     = 3'd2,
    REJECTED    = 3'd3,
    DEB_RELEASE = 3'd4
  } state_t;

  logic       btn_m;
  logic       btn_s;
  logic [1:0] coins_m;
  logic [1:0] coins_s;

  state_t           state;
  state_t           state_n;
  logic [DW-1:0]    cnt;
  logic [DW-1:0]    cnt_n;
  logic             insert_n;
  logic [1:0]       coins_n;
  logic             reject_n;
  logic [CNT_W-1:0] acc_n;
  logic             coin_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      coins_m <= 2'b00;
      coins_s <= 2'b00;
    end else begin
      btn_m   <= btn_raw;
      btn_s   <= btn_m;
      coins_m <= coins_raw;
      coins_s <= coins_m;
    end
  end

  assign coin_ok = (coins_s == 2'b01) || (coins_s == 2'b10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      insert       <= 1'b0;
      coins        <= 2'b00;
      coin_reject  <= 1'b0;
      accepted_cnt <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      insert       <= insert_n;
      coins        <= coins_n;
      coin_reject  <= reject_n;
      accepted_cnt <= acc_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    insert_n = insert;
    coins_n  = coins;
    reject_n = 1'b0;
    acc_n    = accepted_cnt;
    case (state)
      IDLE: begin
        insert_n = 1'b0;
        cnt_n    = '0;
        if (btn_s) begin
          state_n = DEB_PRESS;
          cnt_n   = DW'(1);
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_MAX) begin
          cnt_n = '0;
          if (coin_ok) begin
            state_n  = PRESSED;
            coins_n  = coins_s;
            insert_n = 1'b1;
            acc_n    = accepted_cnt + CNT_W'(1);
          end else begin
            state_n  = REJECTED;
            reject_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + DW'(1);
        end
      end
      PRESSED, REJECTED: begin
        if (!btn_s) begin
          state_n = DEB_RELEASE;
          cnt_n   = DW'(1);
        end
      end
      DEB_RELEASE: begin
        // insert is only ever high when the press was accepted
        if (btn_s) begin
          state_n = insert ? PRESSED : REJECTED;
          cnt_n   = '0;
        end else if (cnt == DEB_MAX) begin
          state_n  = IDLE;
          cnt_n    = '0;
          insert_n = 1'b0;
        end else begin
          cnt_n = cnt + DW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = '0;
        insert_n = 1'b0;
      end
    endcase
  end

endmodule
